ssub_seq: RTL and testbench
===========================

Name: ssub_seq

Overview:
- Sequential signed subtractor; the subtract-direction counterpart of the ALU signed adder in the ALU/Arith/Signed path.
- Computes DIFF = A - B on two's-complement operands, digit-serially (DIGIT bits per clock), with carry held in a register between digits.
- Valid/ready handshake on both input and output, so it can sit behind the ALU operand latch and feed the writeback mux.
- Flags: overflow, negative, zero.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of DIGIT.
- DIGIT, 8, bits processed per SUB cycle; NDIG = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A/B valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend, signed two's complement.
- B  input  WIDTH  subtrahend, signed two's complement.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  A - B, signed.
- ovf  output  1  signed overflow.
- neg  output  1  diff[WIDTH-1].
- zero  output  1  diff == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - diff, ovf, neg, zero = 0.
  - Digit index and carry register = 0.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: latch A into opa and ~B into opb_n, set carry = 1, set digit index k = 0, go to SUB.
- SUB:
  - in_ready = 0.
  - Each edge computes {c, s} = opa[k] + opb_n[k] + carry over DIGIT bits. s is written into diff[k*DIGIT +: DIGIT], carry <= c, k <= k + 1.
  - On the edge that processes k = NDIG-1, go to DONE and set out_valid = 1 on that same edge.
- Latency: out_valid is high NDIG cycles after the acceptance edge (4 cycles at default parameters).
- DONE:
  - out_valid = 1; diff and flags are stable.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE.
  - Accepting the result and accepting new operands never happen on the same edge.
  - Throughput: one op per NDIG + 2 cycles at most.
- Flags are registered together with the last digit:
  - ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]), using the latched operands.
  - neg = diff[W-1].
  - zero = (diff == 0).
- diff is the low WIDTH bits of the exact difference (wrap-around), except as modified by SSUB_SAT_EN.
- Input sampling: A/B are sampled only on the acceptance edge. Changes to A/B after that edge do not affect the result.
- in_valid during SUB/DONE is ignored; in_ready = 0.
- out_ready outside DONE is ignored.
- diff during SUB is intermediate. Consumers must qualify diff with out_valid.
- Reset mid-operation: asserting rst_n low in any state returns immediately to reset values. The partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro: SSUB_SAT_EN.
- Defined: when ovf = 1, diff is clamped.
  - diff = 0x7FFF_FFFF (max positive) if A is non-negative.
  - diff = 0x8000_0000 (min negative) if A is negative.
  - ovf still reports 1.
  - neg and zero are computed from the clamped value.
  - The clamp is applied on the final SUB edge; latency is unchanged.
- Not defined: wrap-around result; no saturation logic is synthesised.

Test Plan:
- A=5, B=3 -> diff=0x00000002, ovf=0, neg=0, zero=0; out_valid rises exactly 4 cycles after the acceptance edge.
- A=0xFFFFFFFB (-5), B=3 -> diff=0xFFFFFFF8 (-8), neg=1, ovf=0; repeat with A=7, B=7 -> diff=0, zero=1.
- A=0x7FFFFFFF, B=0xFFFFFFFF (-1) -> ovf=1, neg=1.
  - Without SSUB_SAT_EN: diff=0x80000000.
  - With SSUB_SAT_EN: diff=0x7FFFFFFF, neg=0.
- A=0x80000000, B=1 -> ovf=1.
  - Without SSUB_SAT_EN: diff=0x7FFFFFFF.
  - With SSUB_SAT_EN: diff=0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles, and toggle A/B and in_valid during that time -> out_valid and diff stay stable and in_ready=0. Then pulse out_ready=1 -> out_valid drops, in_ready=1 on the next cycle, and back-to-back ops produce correct results.
- Reset mid-operation: drop rst_n during SUB (k=2) -> outputs are zero immediately and no out_valid. After release, A=10, B=20 -> diff=0xFFFFFFF6.

Source files
------------

// File: rtl/ssub_seq.sv
// Digit-serial signed subtractor: diff = A - B, DIGIT bits per clock, carry kept between digits.
// Optional saturation on signed overflow when SSUB_SAT_EN is defined.
module ssub_seq #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             ovf,
   output logic             neg,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

   if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_param_check
      $error("ssub_seq: WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]        opa;
   logic [WIDTH-1:0]        opb_n;
   logic                    carry;
   logic [KW-1:0]           k;
   logic [DIGIT:0]          dsum;
   logic signed [WIDTH-1:0] diff_r;
   logic signed [WIDTH-1:0] diff_wrap;
   logic signed [WIDTH-1:0] diff_fin;
   logic                    ovf_fin;
   logic                    ovf_r, neg_r, zero_r;
   logic                    accept;
   logic                    last_dig;

   // Signed overflow of a - b, expressed on the latched minuend and inverted subtrahend:
   // operand signs differ when opa and opb_n share a sign bit.
   function automatic logic sub_ovf(input logic a_msb, input logic bn_msb, input logic d_msb);
      return (a_msb == bn_msb) && (d_msb != a_msb);
   endfunction

`ifdef SSUB_SAT_EN
   function automatic logic signed [WIDTH-1:0] sat_clamp(
      input logic signed [WIDTH-1:0] d,
      input logic                    ov,
      input logic                    a_neg
   );
      logic signed [WIDTH-1:0] r;
      r = d;
      if (ov) r = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      return r;
   endfunction
`endif

   assign accept   = (state == IDLE) && in_valid;
   assign last_dig = (k == KLAST);

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SUB;
         end
         SUB: begin
            if (last_dig) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // One digit of opa + ~B + carry; the final digit also yields the flags.
   always_comb begin
      dsum = {1'b0, opa[k*DIGIT +: DIGIT]} + {1'b0, opb_n[k*DIGIT +: DIGIT]}
             + {{DIGIT{1'b0}}, carry};
      diff_wrap = diff_r;
      diff_wrap[k*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
      ovf_fin = sub_ovf(opa[WIDTH-1], opb_n[WIDTH-1], diff_wrap[WIDTH-1]);
`ifdef SSUB_SAT_EN
      diff_fin = sat_clamp(diff_wrap, ovf_fin, opa[WIDTH-1]);
`else
      diff_fin = diff_wrap;
`endif
   end

   // Operand latch: data only, loaded on the acceptance edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         opa   <= A;
         opb_n <= ~B;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry  <= 1'b0;
         k      <= '0;
         diff_r <= '0;
         ovf_r  <= 1'b0;
         neg_r  <= 1'b0;
         zero_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= 1'b1;
                  k     <= '0;
               end
            end
            SUB: begin
               carry <= dsum[DIGIT];
               k     <= k + KW'(1);
               if (last_dig) begin
                  diff_r <= diff_fin;
                  ovf_r  <= ovf_fin;
                  neg_r  <= diff_fin[WIDTH-1];
                  zero_r <= (diff_fin == '0);
               end else begin
                  diff_r <= diff_wrap;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff = diff_r;
   assign ovf  = ovf_r;
   assign neg  = neg_r;
   assign zero = zero_r;

endmodule

// File: tb/tb_ssub_seq.sv
// Directed self-checking bench for ssub_seq (default WIDTH=32, DIGIT=8).
// Expectations follow SSUB_SAT_EN when the bench is built with that macro.
module tb_ssub_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        ovf;
   logic        neg;
   logic        zero;

   int tests = 0;
   int fails = 0;

   ssub_seq #(.WIDTH(32), .DIGIT(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .ovf       (ovf),
      .neg       (neg),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one operand pair, scrambles A/B after acceptance, waits (bounded) for out_valid,
   // captures the result and optionally accepts it. Returns on a falling edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit acc,
                         output logic [31:0] d, output logic o, output logic n,
                         output logic z, output int lat);
      @(negedge clk);
      A = a;
      B = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      A = 32'hDEADBEEF;
      B = 32'h0BADF00D;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      d = diff;
      o = ovf;
      n = neg;
      z = zero;
      if (acc) begin
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      tests++;
      if ({diff, ovf, neg, zero} !== 35'd0) begin
         fails++; $display("FAIL reset_outputs: got diff=%h ovf=%b neg=%b zero=%b expected all 0",
                           diff, ovf, neg, zero);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] d; logic o, n, z; int lat;
      run_op(32'd5, 32'd3, 1'b1, d, o, n, z, lat);
      tests++;
      if (lat !== 4) begin
         fails++; $display("FAIL basic_latency: got %0d cycles expected 4", lat);
      end
      tests++;
      if ({d, o, n, z} !== {32'h00000002, 3'b000}) begin
         fails++; $display("FAIL basic_5_minus_3: got diff=%h ovf=%b neg=%b zero=%b expected 00000002 0 0 0",
                           d, o, n, z);
      end
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0 1",
                           out_valid, in_ready);
      end
   endtask

   task automatic test_negative_zero();
      logic [31:0] d; logic o, n, z; int lat;
      run_op(32'hFFFFFFFB, 32'd3, 1'b1, d, o, n, z, lat);
      tests++;
      if ({d, o, n, z} !== {32'hFFFFFFF8, 3'b010}) begin
         fails++; $display("FAIL neg_m5_minus_3: got diff=%h ovf=%b neg=%b zero=%b expected fffffff8 0 1 0",
                           d, o, n, z);
      end
      run_op(32'd7, 32'd7, 1'b1, d, o, n, z, lat);
      tests++;
      if ({d, o, n, z} !== {32'h00000000, 3'b001}) begin
         fails++; $display("FAIL zero_7_minus_7: got diff=%h ovf=%b neg=%b zero=%b expected 00000000 0 0 1",
                           d, o, n, z);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d; logic o, n, z; int lat;
      logic [31:0] exp_d1, exp_d2;
      logic        exp_n1, exp_n2;
`ifdef SSUB_SAT_EN
      exp_d1 = 32'h7FFFFFFF; exp_n1 = 1'b0;
      exp_d2 = 32'h80000000; exp_n2 = 1'b1;
`else
      exp_d1 = 32'h80000000; exp_n1 = 1'b1;
      exp_d2 = 32'h7FFFFFFF; exp_n2 = 1'b0;
`endif
      run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, d, o, n, z, lat);
      tests++;
      if ({d, o, n, z} !== {exp_d1, 1'b1, exp_n1, 1'b0}) begin
         fails++; $display("FAIL ovf_max_minus_m1: got diff=%h ovf=%b neg=%b zero=%b expected %h 1 %b 0",
                           d, o, n, z, exp_d1, exp_n1);
      end
      tests++;
      if (lat !== 4) begin
         fails++; $display("FAIL ovf_latency: got %0d cycles expected 4", lat);
      end
      run_op(32'h80000000, 32'h00000001, 1'b1, d, o, n, z, lat);
      tests++;
      if ({d, o, n, z} !== {exp_d2, 1'b1, exp_n2, 1'b0}) begin
         fails++; $display("FAIL ovf_min_minus_1: got diff=%h ovf=%b neg=%b zero=%b expected %h 1 %b 0",
                           d, o, n, z, exp_d2, exp_n2);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic o, n, z; int lat;
      int bad;
      run_op(32'd100, 32'd58, 1'b0, d, o, n, z, lat);
      tests++;
      if (d !== 32'h0000002A || lat !== 4) begin
         fails++; $display("FAIL bp_result: got diff=%h lat=%0d expected 0000002a lat=4", d, lat);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         A = 32'h01010101 * i;
         B = ~(32'h00110011 * i);
         in_valid = i[0];
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b1 || diff !== 32'h0000002A || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_cycle%0d: got out_valid=%b diff=%h in_ready=%b expected 1 0000002a 0",
                     i, out_valid, diff, in_ready);
         end
      end
      tests++;
      if (bad != 0) fails++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1",
                           out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic o, n, z; int lat;
      logic [31:0] va [4];
      logic [31:0] vb [4];
      logic [34:0] ve [4];
      va[0] = 32'd1000;     vb[0] = 32'd1;        ve[0] = {32'h000003E7, 3'b000};
      va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; ve[1] = {32'h00000000, 3'b001};
      va[2] = 32'd0;        vb[2] = 32'd1;        ve[2] = {32'hFFFFFFFF, 3'b010};
      va[3] = 32'h12345678; vb[3] = 32'h11111111; ve[3] = {32'h01234567, 3'b000};
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], 1'b1, d, o, n, z, lat);
         tests++;
         if ({d, o, n, z} !== ve[i] || lat !== 4) begin
            fails++;
            $display("FAIL b2b_op%0d: got diff=%h ovf=%b neg=%b zero=%b lat=%0d expected %h %b%b%b lat=4",
                     i, d, o, n, z, lat, ve[i][34:3], ve[i][2], ve[i][1], ve[i][0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic o, n, z; int lat;
      int seen;
      @(negedge clk);
      A = 32'h11223344;
      B = 32'h01010101;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({diff, ovf, neg, zero} !== 35'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL midrst_immediate: got diff=%h flags=%b%b%b out_valid=%b in_ready=%b expected 0 000 0 1",
                           diff, ovf, neg, zero, out_valid, in_ready);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) rst_n = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++; $display("FAIL midrst_no_valid: got %0d cycles with out_valid expected 0", seen);
      end
      run_op(32'd10, 32'd20, 1'b1, d, o, n, z, lat);
      tests++;
      if ({d, o, n, z} !== {32'hFFFFFFF6, 3'b010} || lat !== 4) begin
         fails++; $display("FAIL midrst_after: got diff=%h ovf=%b neg=%b zero=%b lat=%0d expected fffffff6 0 1 0 lat=4",
                           d, o, n, z, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative_zero();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
